ifsram_pingpong_ctrl: RTL and testbench

//  Sequences the two ifmap SRAM banks (b0/b1) as a ping-pong buffer for one layer.
//  - Store side: pulses start_if_store and drives the bank write selects.
//  - Read/PE side: pulses start_if_read and drives the bank read selects.
//  - Lets the next tile be filled while the current tile is drained; raises layer_done when all tiles are consumed.

---
 rtl/ifsram_pingpong_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_ifsram_pingpong_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifsram_pingpong_ctrl.sv
// Ping-pong sequencer for the two ifmap SRAM banks: fills one bank while the other drains.
// Optional stall counters are enabled by defining IFCTRL_STALL_CNT_EN.
module ifsram_pingpong_ctrl #(
   parameter int unsigned TILE_CNT_BITS  = 16
`ifdef IFCTRL_STALL_CNT_EN
   ,
   parameter int unsigned STALL_CNT_BITS = 32
`endif
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      layer_start,
   input  logic [TILE_CNT_BITS-1:0]  cfg_tile_num,
   output logic                      layer_busy,
   output logic                      layer_done,
   output logic                      start_if_store,
   input  logic                      if_store_busy,
   input  logic                      if_store_done,
   output logic                      start_if_read,
   input  logic                      if_read_done,
   output logic                      ifsramb0_write,
   output logic                      ifsramb1_write,
   output logic                      ifsramb0_read,
   output logic                      ifsramb1_read,
   output logic [1:0]                bank_full
`ifdef IFCTRL_STALL_CNT_EN
   ,
   output logic [STALL_CNT_BITS-1:0] stall_wr_cnt,
   output logic [STALL_CNT_BITS-1:0] stall_rd_cnt
`endif
);

   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_FILL} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRAIN} rd_state_e;

   localparam logic [TILE_CNT_BITS-1:0] TILE_ONE = {{(TILE_CNT_BITS-1){1'b0}}, 1'b1};

   wr_state_e                wst_q, wst_d;
   rd_state_e                rst_q, rst_d;
   logic [TILE_CNT_BITS-1:0] tile_num_q, tile_num_d;
   logic [TILE_CNT_BITS-1:0] issued_q, issued_d;
   logic [TILE_CNT_BITS-1:0] drained_q, drained_d;
   logic                     wr_ptr_q, wr_ptr_d;
   logic                     rd_ptr_q, rd_ptr_d;
   logic [1:0]               bank_full_q, bank_full_d;
   logic [1:0]               wsel_q, wsel_d;
   logic [1:0]               rsel_q, rsel_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     st_start_q, st_start_d;
   logic                     rd_start_q, rd_start_d;
   logic                     accept;

`ifdef IFCTRL_STALL_CNT_EN
   localparam logic [STALL_CNT_BITS-1:0] STALL_ONE = {{(STALL_CNT_BITS-1){1'b0}}, 1'b1};
   logic [STALL_CNT_BITS-1:0] stall_wr_q, stall_wr_d;
   logic [STALL_CNT_BITS-1:0] stall_rd_q, stall_rd_d;
`endif

   assign accept = layer_start && !busy_q;

   always_comb begin
      wst_d       = wst_q;
      rst_d       = rst_q;
      tile_num_d  = tile_num_q;
      issued_d    = issued_q;
      drained_d   = drained_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      bank_full_d = bank_full_q;
      wsel_d      = wsel_q;
      rsel_d      = rsel_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      st_start_d  = 1'b0;
      rd_start_d  = 1'b0;
`ifdef IFCTRL_STALL_CNT_EN
      stall_wr_d  = stall_wr_q;
      stall_rd_d  = stall_rd_q;
      if (wst_q == W_WAIT && issued_q < tile_num_q &&
          (bank_full_q[wr_ptr_q] || rsel_q[wr_ptr_q]) && stall_wr_q != '1)
         stall_wr_d = stall_wr_q + STALL_ONE;
      if (rst_q == R_WAIT && !bank_full_q[rd_ptr_q] && stall_rd_q != '1)
         stall_rd_d = stall_rd_q + STALL_ONE;
`endif

      unique case (wst_q)
         W_WAIT: begin
            if (issued_q < tile_num_q && !bank_full_q[wr_ptr_q] &&
                !rsel_q[wr_ptr_q] && !if_store_busy) begin
               wst_d            = W_FILL;
               st_start_d       = 1'b1;
               wsel_d[wr_ptr_q] = 1'b1;
            end
         end
         W_FILL: begin
            if (if_store_done) begin
               wsel_d                = '0;
               bank_full_d[wr_ptr_q] = 1'b1;
               wr_ptr_d              = ~wr_ptr_q;
               issued_d              = issued_q + TILE_ONE;
               wst_d                 = (issued_d == tile_num_q) ? W_IDLE : W_WAIT;
            end
         end
         default: ;
      endcase

      // Store-done and read-done in one cycle always target different banks,
      // so the set above and the clear below never collide.
      unique case (rst_q)
         R_WAIT: begin
            if (bank_full_q[rd_ptr_q]) begin
               rst_d            = R_DRAIN;
               rd_start_d       = 1'b1;
               rsel_d[rd_ptr_q] = 1'b1;
            end
         end
         R_DRAIN: begin
            if (if_read_done) begin
               rsel_d                = '0;
               bank_full_d[rd_ptr_q] = 1'b0;
               rd_ptr_d              = ~rd_ptr_q;
               drained_d             = drained_q + TILE_ONE;
               if (drained_d == tile_num_q) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
                  wst_d  = W_IDLE;
                  rst_d  = R_IDLE;
               end else begin
                  rst_d  = R_WAIT;
               end
            end
         end
         default: ;
      endcase

      if (accept) begin
         tile_num_d  = cfg_tile_num;
         issued_d    = '0;
         drained_d   = '0;
         wr_ptr_d    = 1'b0;
         rd_ptr_d    = 1'b0;
         bank_full_d = '0;
         wsel_d      = '0;
         rsel_d      = '0;
`ifdef IFCTRL_STALL_CNT_EN
         stall_wr_d  = '0;
         stall_rd_d  = '0;
`endif
         if (cfg_tile_num == '0) begin
            done_d = 1'b1;
         end else begin
            busy_d = 1'b1;
            wst_d  = W_WAIT;
            rst_d  = R_WAIT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wst_q       <= W_IDLE;
         rst_q       <= R_IDLE;
         tile_num_q  <= '0;
         issued_q    <= '0;
         drained_q   <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         bank_full_q <= '0;
         wsel_q      <= '0;
         rsel_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         st_start_q  <= 1'b0;
         rd_start_q  <= 1'b0;
`ifdef IFCTRL_STALL_CNT_EN
         stall_wr_q  <= '0;
         stall_rd_q  <= '0;
`endif
      end else begin
         wst_q       <= wst_d;
         rst_q       <= rst_d;
         tile_num_q  <= tile_num_d;
         issued_q    <= issued_d;
         drained_q   <= drained_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         bank_full_q <= bank_full_d;
         wsel_q      <= wsel_d;
         rsel_q      <= rsel_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         st_start_q  <= st_start_d;
         rd_start_q  <= rd_start_d;
`ifdef IFCTRL_STALL_CNT_EN
         stall_wr_q  <= stall_wr_d;
         stall_rd_q  <= stall_rd_d;
`endif
      end
   end

   assign layer_busy     = busy_q;
   assign layer_done     = done_q;
   assign start_if_store = st_start_q;
   assign start_if_read  = rd_start_q;
   assign ifsramb0_write = wsel_q[0];
   assign ifsramb1_write = wsel_q[1];
   assign ifsramb0_read  = rsel_q[0];
   assign ifsramb1_read  = rsel_q[1];
   assign bank_full      = bank_full_q;
`ifdef IFCTRL_STALL_CNT_EN
   assign stall_wr_cnt   = stall_wr_q;
   assign stall_rd_cnt   = stall_rd_q;
`endif

endmodule

// File: tb/tb_ifsram_pingpong_ctrl.sv
// Bench for ifsram_pingpong_ctrl: bench-side store/read engines, a bank-order scoreboard
// and a start-timing model. Stall-counter checks build when IFCTRL_STALL_CNT_EN is defined.
module tb_ifsram_pingpong_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        layer_start;
   logic [15:0] cfg_tile_num;
   logic        layer_busy, layer_done;
   logic        start_if_store, if_store_busy, if_store_done;
   logic        start_if_read, if_read_done;
   logic        ifsramb0_write, ifsramb1_write, ifsramb0_read, ifsramb1_read;
   logic [1:0]  bank_full;
`ifdef IFCTRL_STALL_CNT_EN
   logic [31:0] stall_wr_cnt, stall_rd_cnt;
`endif

   always #5 clk = ~clk;

   ifsram_pingpong_ctrl #(.TILE_CNT_BITS(16)) dut (
      .clk(clk), .reset(reset),
      .layer_start(layer_start), .cfg_tile_num(cfg_tile_num),
      .layer_busy(layer_busy), .layer_done(layer_done),
      .start_if_store(start_if_store), .if_store_busy(if_store_busy), .if_store_done(if_store_done),
      .start_if_read(start_if_read), .if_read_done(if_read_done),
      .ifsramb0_write(ifsramb0_write), .ifsramb1_write(ifsramb1_write),
      .ifsramb0_read(ifsramb0_read), .ifsramb1_read(ifsramb1_read),
      .bank_full(bank_full)
`ifdef IFCTRL_STALL_CNT_EN
      , .stall_wr_cnt(stall_wr_cnt), .stall_rd_cnt(stall_rd_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   int sq[$], rq[$];
   int ss[$], sd[$], rs[$], rd[$];
   int sel_err, bf_err, ovl_err, extra_err, tim_err;
   int max11, busy_cnt, done_cnt, done_cyc, exp_stall_rd;
   bit timed_out;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One layer: drives layer_start at the current negedge (cycle 0), then plays the
   // store/read engines cycle by cycle, sampling DUT outputs on negedges.
   task automatic run_layer(input int n, input int st_lat, input int rd_lat,
                            input int restart_at, input int spur_at);
      int cyc, st_cnt, rd_cnt, st_bank, rd_bank, run11, e_ss, e_rs;
      bit st_act, rd_act;
      logic [1:0] bf_m, ew, er;
      sq.delete(); rq.delete(); ss.delete(); sd.delete(); rs.delete(); rd.delete();
      sel_err = 0; bf_err = 0; ovl_err = 0; extra_err = 0; tim_err = 0;
      max11 = 0; run11 = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; exp_stall_rd = 0;
      timed_out = 0; st_act = 0; rd_act = 0; st_cnt = 0; rd_cnt = 0;
      st_bank = 0; rd_bank = 0; bf_m = 2'b00;
      for (int i = 0; i < n; i++) begin
         sq.push_back(i % 2);
         rq.push_back(i % 2);
      end
      cfg_tile_num = 16'(n);
      layer_start  = 1'b1;
      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         layer_start = (cyc == restart_at);
         if (cyc == restart_at) cfg_tile_num = 16'd7;
         if (bank_full !== bf_m) bf_err++;
         if (start_if_store === 1'b1) begin
            if (sq.size() == 0) extra_err++;
            else begin
               st_bank = sq.pop_front(); ss.push_back(cyc); st_act = 1; st_cnt = st_lat;
            end
         end
         if (start_if_read === 1'b1) begin
            if (rq.size() == 0) extra_err++;
            else begin
               rd_bank = rq.pop_front(); rs.push_back(cyc); rd_act = 1; rd_cnt = rd_lat;
            end
         end
         ew = 2'b00; if (st_act) ew[st_bank] = 1'b1;
         er = 2'b00; if (rd_act) er[rd_bank] = 1'b1;
         if ({ifsramb1_write, ifsramb0_write} !== ew) sel_err++;
         if ({ifsramb1_read, ifsramb0_read} !== er) sel_err++;
         if ((ifsramb0_write & ifsramb0_read) | (ifsramb1_write & ifsramb1_read)) ovl_err++;
         if (bank_full === 2'b11) run11++; else run11 = 0;
         if (run11 > max11) max11 = run11;
         if (layer_busy === 1'b1) busy_cnt++;
         if (layer_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
         if_store_done = 1'b0;
         if_read_done  = 1'b0;
         if (st_act) begin
            st_cnt--;
            if (st_cnt == 0) begin
               if_store_done = 1'b1; sd.push_back(cyc); st_act = 0; bf_m[st_bank] = 1'b1;
            end
         end
         if (rd_act) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               if_read_done = 1'b1; rd.push_back(cyc); rd_act = 0; bf_m[rd_bank] = 1'b0;
            end
         end
         if (cyc == spur_at && !rd_act) if_read_done = 1'b1;
         if_store_busy = st_act;
         if (done_cnt > 0 && cyc >= done_cyc + 3) break;
         if (cyc >= 3000) begin timed_out = 1; break; end
      end
      layer_start = 1'b0; if_store_done = 1'b0; if_read_done = 1'b0; if_store_busy = 1'b0;
      // Expected start cycles: 1 cycle accept, 1 cycle to issue, visible next negedge.
      if (ss.size() != n || rs.size() != n || sd.size() != n || rd.size() != n) tim_err++;
      else begin
         for (int i = 0; i < n; i++) begin
            e_ss = (i == 0) ? 2 : (i == 1) ? sd[0] + 2 : imax(sd[i-1], rd[i-2]) + 2;
            e_rs = (i == 0) ? sd[0] + 2 : imax(sd[i], rd[i-1]) + 2;
            if (ss[i] != e_ss) tim_err++;
            if (rs[i] != e_rs) tim_err++;
            exp_stall_rd += (i == 0) ? sd[0] : imax(sd[i] - rd[i-1], 0);
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++; if ({layer_busy, layer_done, start_if_store, start_if_read} !== 4'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {layer_busy, layer_done, start_if_store, start_if_read}); end
      n_checks++; if ({ifsramb1_write, ifsramb0_write, ifsramb1_read, ifsramb0_read} !== 4'b0) begin
         n_fail++; $display("FAIL reset_sel: got %b want 0000", {ifsramb1_write, ifsramb0_write, ifsramb1_read, ifsramb0_read}); end
      n_checks++; if (bank_full !== 2'b00) begin
         n_fail++; $display("FAIL reset_bank_full: got %b want 00", bank_full); end
`ifdef IFCTRL_STALL_CNT_EN
      n_checks++; if ({stall_wr_cnt, stall_rd_cnt} !== 64'd0) begin
         n_fail++; $display("FAIL reset_stall: got %0d/%0d want 0/0", stall_wr_cnt, stall_rd_cnt); end
`endif
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      run_layer(3, 10, 10, -1, 5);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL t1_timeout: got 1 want 0"); end
      n_checks++; if (ss.size() !== 3 || rs.size() !== 3) begin
         n_fail++; $display("FAIL t1_starts: got %0d/%0d want 3/3", ss.size(), rs.size()); end
      n_checks++; if (extra_err + sq.size() + rq.size() !== 0) begin
         n_fail++; $display("FAIL t1_scoreboard: got %0d leftover/extra want 0", extra_err + sq.size() + rq.size()); end
      n_checks++; if (sel_err !== 0) begin n_fail++; $display("FAIL t1_selects: got %0d bad cycles want 0", sel_err); end
      n_checks++; if (bf_err !== 0) begin n_fail++; $display("FAIL t1_bank_full: got %0d bad cycles want 0", bf_err); end
      n_checks++; if (ovl_err !== 0) begin n_fail++; $display("FAIL t1_overlap: got %0d want 0", ovl_err); end
      n_checks++; if (tim_err !== 0) begin n_fail++; $display("FAIL t1_timing: got %0d errors want 0", tim_err); end
      if (ss.size() == 3 && rd.size() == 3) begin
         n_checks++; if (ss[2] !== rd[0] + 2) begin
            n_fail++; $display("FAIL t1_refill_b0: got cycle %0d want %0d", ss[2], rd[0] + 2); end
         n_checks++; if (done_cyc !== rd[2] + 1) begin
            n_fail++; $display("FAIL t1_done_time: got cycle %0d want %0d", done_cyc, rd[2] + 1); end
      end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t1_done_cnt: got %0d want 1", done_cnt); end
      n_checks++; if (busy_cnt !== done_cyc - 1) begin
         n_fail++; $display("FAIL t1_busy_len: got %0d want %0d", busy_cnt, done_cyc - 1); end
   endtask

   task automatic test_zero_tiles;
      run_layer(0, 10, 10, -1, -1);
      n_checks++; if (done_cyc !== 1) begin n_fail++; $display("FAIL t2_done_time: got %0d want 1", done_cyc); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t2_done_cnt: got %0d want 1", done_cnt); end
      n_checks++; if (ss.size() + rs.size() + extra_err !== 0) begin
         n_fail++; $display("FAIL t2_no_starts: got %0d starts want 0", ss.size() + rs.size() + extra_err); end
      n_checks++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL t2_busy: got %0d cycles want 0", busy_cnt); end
   endtask

   task automatic test_spurious_idle;
      if_store_done = 1'b1; if_read_done = 1'b1;
      @(negedge clk);
      if_store_done = 1'b0; if_read_done = 1'b0;
      @(negedge clk);
      n_checks++; if ({bank_full, layer_done, layer_busy, start_if_store, start_if_read} !== 6'b0) begin
         n_fail++; $display("FAIL spurious_idle: got %b want 000000",
                            {bank_full, layer_done, layer_busy, start_if_store, start_if_read}); end
   endtask

   task automatic test_slow_read;
      run_layer(4, 10, 50, -1, -1);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL t3_timeout: got 1 want 0"); end
      if (ss.size() == 4 && rd.size() == 4) begin
         n_checks++; if (ss[2] !== rd[0] + 2) begin
            n_fail++; $display("FAIL t3_third_fill: got cycle %0d want %0d", ss[2], rd[0] + 2); end
      end
      n_checks++; if (max11 > 50 || max11 < 1) begin
         n_fail++; $display("FAIL t3_both_full: got %0d cycles want 1..50", max11); end
      n_checks++; if (tim_err + sel_err + bf_err + ovl_err + extra_err !== 0) begin
         n_fail++; $display("FAIL t3_sequence: got %0d errors want 0", tim_err + sel_err + bf_err + ovl_err + extra_err); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t3_done_cnt: got %0d want 1", done_cnt); end
   endtask

   task automatic test_busy_restart;
      run_layer(3, 6, 6, 15, -1);
      n_checks++; if (ss.size() !== 3 || rs.size() !== 3) begin
         n_fail++; $display("FAIL t4_starts: got %0d/%0d want 3/3", ss.size(), rs.size()); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t4_done_cnt: got %0d want 1", done_cnt); end
      n_checks++; if (tim_err + sel_err + bf_err + extra_err !== 0) begin
         n_fail++; $display("FAIL t4_sequence: got %0d errors want 0", tim_err + sel_err + bf_err + extra_err); end
   endtask

   task automatic test_back_to_back;
      run_layer(5, 12, 4, -1, -1);
      n_checks++; if (tim_err + sel_err + bf_err + ovl_err + extra_err !== 0 || done_cnt !== 1) begin
         n_fail++; $display("FAIL b2b_first: got %0d errors, %0d dones want 0, 1",
                            tim_err + sel_err + bf_err + ovl_err + extra_err, done_cnt); end
      run_layer(6, 3, 7, -1, -1);
      n_checks++; if (tim_err + sel_err + bf_err + ovl_err + extra_err !== 0 || done_cnt !== 1) begin
         n_fail++; $display("FAIL b2b_second: got %0d errors, %0d dones want 0, 1",
                            tim_err + sel_err + bf_err + ovl_err + extra_err, done_cnt); end
   endtask

   task automatic test_reset_mid;
      bit seen;
      cfg_tile_num = 16'd2; layer_start = 1'b1;
      @(negedge clk);
      layer_start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (start_if_store === 1'b1) seen = 1;
      end
      n_checks++; if (seen !== 1'b1 || ifsramb0_write !== 1'b1) begin
         n_fail++; $display("FAIL t5_fill_start: got seen=%0d b0w=%b want 1/1", seen, ifsramb0_write); end
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_checks++; if ({ifsramb1_write, ifsramb0_write, ifsramb1_read, ifsramb0_read, layer_busy, bank_full} !== 7'b0) begin
         n_fail++; $display("FAIL t5_async_clear: got %b want 0000000",
                            {ifsramb1_write, ifsramb0_write, ifsramb1_read, ifsramb0_read, layer_busy, bank_full}); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_layer(2, 5, 5, -1, -1);
      n_checks++; if (ss.size() !== 2 || ss[0] !== 2) begin
         n_fail++; $display("FAIL t5_restart: got %0d starts, first at %0d want 2, 2",
                            ss.size(), (ss.size() > 0) ? ss[0] : -1); end
      n_checks++; if (tim_err + sel_err + bf_err + extra_err !== 0 || done_cnt !== 1) begin
         n_fail++; $display("FAIL t5_sequence: got %0d errors, %0d dones want 0, 1",
                            tim_err + sel_err + bf_err + extra_err, done_cnt); end
   endtask

`ifdef IFCTRL_STALL_CNT_EN
   task automatic test_stall_counters;
      run_layer(3, 10, 20, -1, -1);
      n_checks++; if (stall_wr_cnt == 32'd0) begin
         n_fail++; $display("FAIL t6_stall_wr: got %0d want >0", stall_wr_cnt); end
      n_checks++; if (stall_rd_cnt !== 32'(exp_stall_rd)) begin
         n_fail++; $display("FAIL t6_stall_rd: got %0d want %0d", stall_rd_cnt, exp_stall_rd); end
   endtask
`endif

   initial begin
      reset = 1'b0; layer_start = 1'b0; cfg_tile_num = '0;
      if_store_busy = 1'b0; if_store_done = 1'b0; if_read_done = 1'b0;
      test_reset();
      test_basic();
      test_zero_tiles();
      test_spurious_idle();
      test_slow_read();
      test_busy_restart();
      test_back_to_back();
      test_reset_mid();
`ifdef IFCTRL_STALL_CNT_EN
      test_stall_counters();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
